// File: rtl/dbg_uart_pkg.sv
// ============================================================================
// Module  : dbg_uart_pkg
// Brief   : Shared types and constants for the uart debug responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dbg_uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SEND   = 2'd2,
        GAP    = 2'd3
    } dbg_state_t;

    localparam logic [7:0] CMD_PING       = 8'h7F;
    localparam int         CMD_READ_BIT   = 7;

    localparam logic [7:0] HDR_OK_DEFAULT   = 8'hA5;
    localparam logic [7:0] HDR_ERR_DEFAULT  = 8'hEE;
    localparam logic [7:0] PING_ACK_DEFAULT = 8'h5A;

    localparam logic [3:0] LEN_BIN = 4'd5;
    localparam logic [3:0] LEN_HEX = 4'd10;

endpackage

`default_nettype wire

// File: rtl/uart_debug_responder_if.sv
// ============================================================================
// Module  : uart_debug_responder_if
// Brief   : Byte-level uart rx/tx handshake between the responder and the uart.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_debug_responder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_re;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       tx_busy;

    modport master (
        input  rx_data, rx_valid, tx_busy,
        output rx_re, tx_data, tx_we
    );

    modport slave (
        output rx_data, rx_valid, tx_busy,
        input  rx_re, tx_data, tx_we
    );
endinterface

`default_nettype wire

// File: rtl/dbg_hex_ascii.sv
// ============================================================================
// Module  : dbg_hex_ascii
// Brief   : Combinational nibble to uppercase ASCII hex digit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dbg_hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_debug_responder.sv
// ============================================================================
// Module  : uart_debug_responder
// Brief   : Debugger command responder: ping, probe-word read, error reply.
//           Define DBG_HEX_ASCII_EN for ASCII-hex read payloads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_debug_responder
    import dbg_uart_pkg::*;
#(
    parameter int         NUM_PROBES = 12,
    parameter logic [7:0] HDR_OK     = HDR_OK_DEFAULT,
    parameter logic [7:0] HDR_ERR    = HDR_ERR_DEFAULT,
    parameter logic [7:0] PING_ACK   = PING_ACK_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PROBES*32-1:0] probe_bus,
    uart_debug_responder_if.master   uart,
    output logic                     dbg_active,
    output logic [7:0]               err_cnt
);

`ifdef DBG_HEX_ASCII_EN
    localparam logic [3:0] c_len_read = LEN_HEX;
`else
    localparam logic [3:0] c_len_read = LEN_BIN;
`endif

    dbg_state_t  r_state;
    logic [7:0]  r_cmd;
    logic [7:0]  r_hdr;
    logic [31:0] r_snap;
    logic [3:0]  r_len;
    logic [3:0]  r_cnt;
    logic        r_dbg_active;
    logic [7:0]  r_err_cnt;

    logic [6:0]  w_idx;
    logic        w_idx_ok;
    logic [31:0] w_probe_word;
    logic [7:0]  w_byte;
    logic        w_send;

    assign w_idx    = r_cmd[6:0];
    assign w_idx_ok = ({25'd0, w_idx} < 32'(NUM_PROBES));

    always_comb begin
        w_probe_word = 32'h0;
        for (int k = 0; k < NUM_PROBES; k++) begin
            if (w_idx == 7'(k)) begin
                w_probe_word = probe_bus[32*k +: 32];
            end
        end
    end

`ifdef DBG_HEX_ASCII_EN
    logic [3:0] w_nibble;
    logic [7:0] w_ascii;

    always_comb begin
        case (r_cnt)
            4'd1:    w_nibble = r_snap[31:28];
            4'd2:    w_nibble = r_snap[27:24];
            4'd3:    w_nibble = r_snap[23:20];
            4'd4:    w_nibble = r_snap[19:16];
            4'd5:    w_nibble = r_snap[15:12];
            4'd6:    w_nibble = r_snap[11:8];
            4'd7:    w_nibble = r_snap[7:4];
            4'd8:    w_nibble = r_snap[3:0];
            default: w_nibble = 4'h0;
        endcase
    end

    dbg_hex_ascii u_hex_ascii (
        .nibble (w_nibble),
        .ascii  (w_ascii)
    );

    always_comb begin
        if (r_cnt == 4'd0) begin
            w_byte = r_hdr;
        end else if (r_cnt == 4'd9) begin
            w_byte = 8'h0A;
        end else begin
            w_byte = w_ascii;
        end
    end
`else
    always_comb begin
        case (r_cnt)
            4'd1:    w_byte = r_snap[31:24];
            4'd2:    w_byte = r_snap[23:16];
            4'd3:    w_byte = r_snap[15:8];
            4'd4:    w_byte = r_snap[7:0];
            default: w_byte = r_hdr;
        endcase
    end
`endif

    // Strobes are decoded from the registered state so the uart consumes/loads
    // in the IDLE/SEND cycle itself; GAP then absorbs the busy-flag latency.
    assign w_send       = !rst && (r_state == SEND) && !uart.tx_busy;
    assign uart.tx_we   = w_send;
    assign uart.tx_data = w_send ? w_byte : 8'h00;
    assign uart.rx_re   = !rst && (r_state == IDLE) && uart.rx_valid;

    assign dbg_active = r_dbg_active;
    assign err_cnt    = r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cmd        <= 8'h00;
            r_hdr        <= 8'h00;
            r_snap       <= 32'h0;
            r_len        <= 4'd0;
            r_cnt        <= 4'd0;
            r_dbg_active <= 1'b0;
            r_err_cnt    <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (uart.rx_valid) begin
                        r_cmd        <= uart.rx_data;
                        r_dbg_active <= 1'b1;
                        r_state      <= DECODE;
                    end
                end
                DECODE: begin
                    r_cnt   <= 4'd0;
                    r_state <= SEND;
                    if (r_cmd == CMD_PING) begin
                        r_hdr <= PING_ACK;
                        r_len <= 4'd1;
                    end else if (r_cmd[CMD_READ_BIT] && w_idx_ok) begin
                        r_hdr  <= HDR_OK;
                        r_len  <= c_len_read;
                        r_snap <= w_probe_word;
                    end else begin
                        r_hdr <= HDR_ERR;
                        r_len <= 4'd1;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                end
                SEND: begin
                    if (!uart.tx_busy) begin
                        r_cnt   <= r_cnt + 4'd1;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_cnt == r_len) begin
                        r_dbg_active <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_state <= SEND;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_debug_responder.sv
// ============================================================================
// Module  : tb_uart_debug_responder
// Brief   : Scoreboard bench for uart_debug_responder (binary or hex build).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_debug_responder;

    localparam int NP = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*32-1:0] probe_bus;
    logic             dbg_active;
    logic [7:0]       err_cnt;

    uart_debug_responder_if uart_if ();

    uart_debug_responder #(.NUM_PROBES(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .probe_bus  (probe_bus),
        .uart       (uart_if),
        .dbg_active (dbg_active),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_bad = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         exp_err = 0;
    logic       prev_we = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Output monitor: every tx byte is matched against the scoreboard.
    always @(negedge clk) begin
        if (uart_if.tx_we) begin
            we_cnt++;
            check_val("we_consecutive", 32'(prev_we), 32'd0);
            check_val("we_while_busy", 32'(uart_if.tx_busy), 32'd0);
            check_val("tx_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_val("tx_byte", 32'(uart_if.tx_data), 32'(exp_q.pop_front()));
            end
        end
        if (uart_if.rx_re) begin
            re_cnt++;
            check_val("rx_re_outside_idle", 32'(dbg_active), 32'd0);
        end
        prev_we = uart_if.tx_we;
    end

    function automatic logic [7:0] hexch(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic push_read(input logic [31:0] w);
        exp_q.push_back(8'hA5);
`ifdef DBG_HEX_ASCII_EN
        for (int i = 7; i >= 0; i--) exp_q.push_back(hexch(w[4*i +: 4]));
        exp_q.push_back(8'h0A);
`else
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
`endif
    endtask

    task automatic push_cmd(input logic [7:0] b);
        if (b == 8'h7F) begin
            exp_q.push_back(8'h5A);
        end else if (b[7] && int'(b[6:0]) < NP) begin
            push_read(probe_bus[32*int'(b[6:0]) +: 32]);
        end else begin
            exp_q.push_back(8'hEE);
            if (exp_err < 255) exp_err++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx_re();
        int t = 0;
        @(negedge clk);
        while (!uart_if.rx_re && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val("rx_accept", 32'(uart_if.rx_re), 32'd1);
    endtask

    task automatic present(input logic [7:0] b);
        uart_if.rx_data  = b;
        uart_if.rx_valid = 1'b1;
        wait_rx_re();
        @(posedge clk);
        #1;
        uart_if.rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while ((dbg_active || exp_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val("reply_complete", {30'd0, dbg_active, exp_q.size() == 0}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        push_cmd(b);
        present(b);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int w0;
        rst              = 1'b1;
        uart_if.rx_data  = 8'h00;
        uart_if.rx_valid = 1'b0;
        uart_if.tx_busy  = 1'b0;
        for (int k = 0; k < NP; k++) probe_bus[32*k +: 32] = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
        tick(3);
        rst = 1'b0;

        @(negedge clk);
        check_val("rst_rx_re", 32'(uart_if.rx_re), 32'd0);
        check_val("rst_tx_we", 32'(uart_if.tx_we), 32'd0);
        check_val("rst_tx_data", 32'(uart_if.tx_data), 32'd0);
        check_val("rst_dbg_active", 32'(dbg_active), 32'd0);
        check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick(1);

        // Ping
        r0 = re_cnt;
        w0 = we_cnt;
        send_cmd(8'h7F);
        check_val("ping_rx_re_count", 32'(re_cnt - r0), 32'd1);
        check_val("ping_tx_we_count", 32'(we_cnt - w0), 32'd1);
        check_val("ping_dbg_active", 32'(dbg_active), 32'd0);

        // Read probe 3; probe changes after DECODE must not leak into the reply
        probe_bus[32*3 +: 32] = 32'h0000_1234;
        push_cmd(8'h83);
        uart_if.rx_data  = 8'h83;
        uart_if.rx_valid = 1'b1;
        wait_rx_re();
        tick(1);
        uart_if.rx_valid = 1'b0;
        tick(1);
        probe_bus[32*3 +: 32] = 32'hFFFF_FFFF;
        wait_done();

        // Error replies and index boundary
        send_cmd(8'hC0);
        check_val("err_cnt_1", 32'(err_cnt), 32'd1);
        send_cmd(8'h01);
        check_val("err_cnt_2", 32'(err_cnt), 32'd2);
        send_cmd(8'h8B);
        send_cmd(8'h8C);
        check_val("err_cnt_idx12", 32'(err_cnt), 32'd3);
        for (int i = 0; i < 300; i++) begin
            send_cmd((i % 3 == 0) ? 8'h00 : ((i % 3 == 1) ? 8'hFF : 8'h8C));
        end
        check_val("err_cnt_sat", 32'(err_cnt), 32'hFF);
        check_val("err_cnt_model", 32'(err_cnt), 32'(exp_err));

        // Transmitter busy with a second command pending
        uart_if.tx_busy = 1'b1;
        push_cmd(8'h85);
        present(8'h85);
        push_cmd(8'h7F);
        uart_if.rx_data  = 8'h7F;
        uart_if.rx_valid = 1'b1;
        w0 = we_cnt;
        r0 = re_cnt;
        tick(50);
        check_val("busy_hold_tx_we", 32'(we_cnt - w0), 32'd0);
        check_val("busy_hold_rx_re", 32'(re_cnt - r0), 32'd0);
        uart_if.tx_busy = 1'b0;
        wait_rx_re();
        tick(1);
        uart_if.rx_valid = 1'b0;
        wait_done();
        check_val("busy_rx_re_total", 32'(re_cnt - r0), 32'd1);

        // Reset in the middle of a reply
        probe_bus[32*4 +: 32] = 32'hCAFE_F00D;
        push_cmd(8'h84);
        present(8'h84);
        w0 = we_cnt;
        begin
            int t = 0;
            while (we_cnt - w0 < 2 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        check_val("mid_reply_bytes", 32'(we_cnt - w0), 32'd2);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        check_val("abort_rx_re", 32'(uart_if.rx_re), 32'd0);
        check_val("abort_tx_we", 32'(uart_if.tx_we), 32'd0);
        check_val("abort_tx_data", 32'(uart_if.tx_data), 32'd0);
        check_val("abort_dbg_active", 32'(dbg_active), 32'd0);
        check_val("abort_err_cnt", 32'(err_cnt), 32'd0);
        w0 = we_cnt;
        tick(20);
        check_val("abort_no_resume", 32'(we_cnt - w0), 32'd0);
        w0 = we_cnt;
        send_cmd(8'h7F);
        check_val("post_abort_ping", 32'(we_cnt - w0), 32'd1);

        // Read probe 0 (hex build exercises every nibble class)
        probe_bus[32*0 +: 32] = 32'hDEAD_00BF;
        send_cmd(8'h80);

        tick(5);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
